krnl_partialknn_local_sp_reader: RTL and testbench

Read-side initiator for the partialKnn local scratchpad (URAM 1R1W, 256 b × 2048). Given a start address and beat count, it issues single-port reads, tracks in-flight data across the fixed memory read latency, and streams the words out on a valid/ready interface with a last flag. Internal buffering absorbs downstream backpressure so no read data is ever dropped. It sits between the scratchpad and the distance-compute pipeline.

---
 rtl/krnl_partialknn_sp_pkg.sv | 22 ++
 rtl/krnl_partialknn_sp_skid_fifo.sv | 90 +++++++++
 rtl/krnl_partialknn_local_sp_reader.sv | 178 +++++++++++++++++
 tb/tb_krnl_partialknn_local_sp_reader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/krnl_partialknn_sp_pkg.sv
// rtl/krnl_partialknn_sp_pkg.sv - shared types and constants for the partialKnn scratchpad reader
package krnl_partialknn_sp_pkg;

    localparam int SP_DATA_WIDTH    = 256;
    localparam int SP_ADDRESS_RANGE = 2048;
    localparam int SP_ADDRESS_WIDTH = 11;
    localparam int SP_READ_LATENCY  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sp_state_e;

    // Enough slots to cover every read in the memory pipeline plus a full
    // head/skid pair, so back-to-back issue never waits on a drained FIFO.
    function automatic int sp_fifo_depth(input int read_latency);
        return read_latency + 2;
    endfunction

endpackage

// File: rtl/krnl_partialknn_sp_skid_fifo.sv
// rtl/krnl_partialknn_sp_skid_fifo.sv - synchronous FIFO with registered head, occupancy count and flush
module krnl_partialknn_sp_skid_fifo #(
    parameter int Width      = 257,
    parameter int Depth      = 4,
    parameter int CountWidth = $clog2(Depth + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [Width-1:0]      in_tdata,
    input  logic                  in_tvalid,
    output logic [Width-1:0]      out_tdata,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic [CountWidth-1:0] count
);

    // One slot is the output register itself; the rest form a small ring.
    localparam int BodyDepth    = Depth - 1;
    localparam int PtrWidth     = (BodyDepth > 1) ? $clog2(BodyDepth) : 1;
    localparam int BodyCntWidth = $clog2(BodyDepth + 1);

    logic [Width-1:0]        body_mem [BodyDepth];
    logic [PtrWidth-1:0]     wr_ptr_q;
    logic [PtrWidth-1:0]     rd_ptr_q;
    logic [BodyCntWidth-1:0] body_cnt_q;
    logic                    head_free;
    logic                    body_empty;
    logic                    body_pop;
    logic                    body_push;
    logic                    head_take_in;

    // Head refills from the ring first (oldest data); input bypasses straight
    // into the head only when the ring is empty.
    always_comb begin
        head_free    = !out_tvalid || out_tready;
        body_empty   = (body_cnt_q == '0);
        body_pop     = head_free && !body_empty;
        head_take_in = head_free && body_empty && in_tvalid;
        body_push    = in_tvalid && !head_take_in;
        count        = CountWidth'(body_cnt_q) + CountWidth'(out_tvalid);
    end

    // Ring storage; no reset needed, validity is tracked by the counters.
    always_ff @(posedge clk) begin
        if (body_push) begin
            body_mem[wr_ptr_q] <= in_tdata;
        end
    end

    // Pointers, ring occupancy and the registered head.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            body_cnt_q <= '0;
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
        end else if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            body_cnt_q <= '0;
            out_tvalid <= 1'b0;
        end else begin
            if (body_push) begin
                wr_ptr_q <= (wr_ptr_q == PtrWidth'(BodyDepth - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
            end
            if (body_pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrWidth'(BodyDepth - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
            end
            case ({body_push, body_pop})
                2'b10:   body_cnt_q <= body_cnt_q + BodyCntWidth'(1);
                2'b01:   body_cnt_q <= body_cnt_q - BodyCntWidth'(1);
                default: body_cnt_q <= body_cnt_q;
            endcase
            if (head_free) begin
                if (body_pop) begin
                    out_tdata  <= body_mem[rd_ptr_q];
                    out_tvalid <= 1'b1;
                end else if (head_take_in) begin
                    out_tdata  <= in_tdata;
                    out_tvalid <= 1'b1;
                end else begin
                    out_tvalid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/krnl_partialknn_local_sp_reader.sv
// rtl/krnl_partialknn_local_sp_reader.sv - scratchpad read initiator streaming words out; KNN_SP_READER_STATS_EN adds counters
module krnl_partialknn_local_sp_reader
    import krnl_partialknn_sp_pkg::*;
#(
    parameter int DataWidth    = SP_DATA_WIDTH,
    parameter int AddressRange = SP_ADDRESS_RANGE,
    parameter int AddressWidth = SP_ADDRESS_WIDTH,
    parameter int ReadLatency  = SP_READ_LATENCY
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [AddressWidth-1:0] base_addr,
    input  logic [AddressWidth:0]   length,
    output logic                    busy,
    output logic                    done,
    output logic [AddressWidth-1:0] address0,
    output logic                    ce0,
    output logic                    we0,
    output logic [DataWidth-1:0]    d0,
    input  logic [DataWidth-1:0]    q0,
    output logic [DataWidth-1:0]    out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last
`ifdef KNN_SP_READER_STATS_EN
    ,
    output logic [31:0]             stall_cycles,
    output logic [AddressWidth:0]   beats_out
`endif
);

    localparam int FifoDepth = sp_fifo_depth(ReadLatency);
    localparam int CntWidth  = $clog2(FifoDepth + 1);

    sp_state_e               state_q;
    sp_state_e               state_d;
    logic                    accept;
    logic                    issue;
    logic                    final_issue;
    logic                    has_credit;
    logic                    pop;
    logic [AddressWidth-1:0] base_q;
    logic [AddressWidth:0]   len_q;
    logic [AddressWidth:0]   issued_q;
    logic [ReadLatency-1:0]  vld_q;
    logic [ReadLatency-1:0]  last_q;
    logic [CntWidth-1:0]     inflight_q;
    logic [CntWidth-1:0]     fifo_count;
    logic [CntWidth:0]       outstanding;
    logic [AddressWidth+1:0] addr_sum;
    logic [DataWidth:0]      head_tdata;

    // Issue gating: every read is guaranteed a FIFO slot before it leaves,
    // so backpressure never drops returning data.
    assign accept      = (state_q == ST_IDLE) && start;
    assign outstanding = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign has_credit  = outstanding < (CntWidth + 1)'(FifoDepth);
    assign issue       = (state_q == ST_RUN) && (issued_q < len_q) && has_credit;
    assign final_issue = issue && ((issued_q + (AddressWidth + 1)'(1)) == len_q);
    assign pop         = out_valid && out_ready;

    // Wrap past the last word with a compare-and-subtract so non power of two
    // depths work.
    assign addr_sum = {2'b00, base_q} + {1'b0, issued_q};
    assign address0 = (addr_sum >= (AddressWidth + 2)'(AddressRange))
                    ? AddressWidth'(addr_sum - (AddressWidth + 2)'(AddressRange))
                    : AddressWidth'(addr_sum);

    assign ce0      = issue;
    assign we0      = 1'b0;
    assign d0       = '0;
    assign busy     = accept || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);
    assign out_data = head_tdata[DataWidth-1:0];
    assign out_last = out_valid && head_tdata[DataWidth];

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: zero-length transfers skip straight to the done pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (length == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (final_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && out_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Transfer bookkeeping and the read-latency valid/last pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            vld_q      <= '0;
            last_q     <= '0;
            inflight_q <= '0;
        end else begin
            if (accept) begin
                base_q   <= base_addr;
                len_q    <= length;
                issued_q <= '0;
            end else if (issue) begin
                issued_q <= issued_q + (AddressWidth + 1)'(1);
            end
            vld_q[0]  <= issue;
            last_q[0] <= final_issue;
            for (int k = 1; k < ReadLatency; k++) begin
                vld_q[k]  <= vld_q[k-1];
                last_q[k] <= last_q[k-1];
            end
            case ({issue, vld_q[ReadLatency-1]})
                2'b10:   inflight_q <= inflight_q + CntWidth'(1);
                2'b01:   inflight_q <= inflight_q - CntWidth'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    krnl_partialknn_sp_skid_fifo #(
        .Width      (DataWidth + 1),
        .Depth      (FifoDepth),
        .CountWidth (CntWidth)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (accept),
        .in_tdata   ({last_q[ReadLatency-1], q0}),
        .in_tvalid  (vld_q[ReadLatency-1]),
        .out_tdata  (head_tdata),
        .out_tvalid (out_valid),
        .out_tready (out_ready),
        .count      (fifo_count)
    );

`ifdef KNN_SP_READER_STATS_EN
    // Per-transfer statistics, cleared whenever a new transfer is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            beats_out    <= '0;
        end else if (accept) begin
            stall_cycles <= '0;
            beats_out    <= '0;
        end else begin
            if (busy && out_valid && !out_ready) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (pop) begin
                beats_out <= beats_out + (AddressWidth + 1)'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_krnl_partialknn_local_sp_reader.sv
// tb/tb_krnl_partialknn_local_sp_reader.sv - scoreboard bench for the scratchpad reader
`timescale 1ns/1ps
module tb_krnl_partialknn_local_sp_reader;

    localparam int DW = 256;
    localparam int AW = 11;
    localparam int AR = 2048;
    localparam int RL = 2;
    localparam int FD = RL + 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] address0;
    logic          ce0;
    logic          we0;
    logic [DW-1:0] d0;
    logic [DW-1:0] q0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
`ifdef KNN_SP_READER_STATS_EN
    logic [31:0]   stall_cycles;
    logic [AW:0]   beats_out;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rmode = 0;
    int hold_cnt = 0;
    int ce_total = 0;
    int hs_total = 0;
    int valid_total = 0;
    int maxout = 0;
    beat_t exp_q[$];
    int    exp_adr[$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [DW-1:0] rd_pipe [RL];

    krnl_partialknn_local_sp_reader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .address0  (address0),
        .ce0       (ce0),
        .we0       (we0),
        .d0        (d0),
        .q0        (q0),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
`ifdef KNN_SP_READER_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .beats_out    (beats_out)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] word_of(input int a);
        logic [DW-1:0] w;
        for (int k = 0; k < 8; k++) begin
            w[k*32 +: 32] = (32'(a) * 32'h9E3779B1) ^ (32'(k) * 32'h01000193) ^ 32'hA5A50000;
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] junk_word();
        logic [DW-1:0] w;
        for (int k = 0; k < 8; k++) begin
            w[k*32 +: 32] = $urandom();
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scratchpad model: data appears RL cycles after the enabled cycle.
    always @(posedge clk) begin
        rd_pipe[0] <= ce0 ? word_of(int'(address0)) : junk_word();
        for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign q0 = rd_pipe[RL-1];

    // Downstream ready generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold_cnt > 0) begin
                out_ready = 1'b0;
                hold_cnt--;
            end else if (rmode == 0) begin
                out_ready = 1'b1;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: pops expected reads and beats whenever the DUT presents them.
    always @(negedge clk) begin
        int    a;
        beat_t b;
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_data_held", out_data, prev_data);
                check("stall_last_held", out_last, prev_last);
            end
            if (ce0) begin
                ce_total++;
                tests++;
                if (exp_adr.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_read: address0=%0d with no read expected", address0);
                end else begin
                    a = exp_adr.pop_front();
                    if (address0 !== AW'(a)) begin
                        fails++;
                        $display("FAIL read_addr: got %0d, expected %0d", address0, a);
                    end
                end
            end
            if (out_valid) valid_total++;
            if (out_valid && out_ready) begin
                hs_total++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: out_data=%0h with no beat expected", out_data);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", out_data, b.data);
                    check("beat_last", out_last, b.last);
                end
            end
            if (ce_total - hs_total > maxout) maxout = ce_total - hs_total;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic push_expected(input int base, input int len);
        beat_t b;
        int    a;
        for (int i = 0; i < len; i++) begin
            a = (base + i) % AR;
            exp_adr.push_back(a);
            b.data = word_of(a);
            b.last = (i == len - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic xfer(input int base, input int len, input int mode, input int hold,
                        input int hold_at_valid, input bit chk_lat);
        int t0;
        int lat;
        int busy_n;
        int ce_before;
        int val_before;
        bit got;
        bit armed;
        push_expected(base, len);
        rmode      = mode;
        maxout     = 0;
        ce_before  = ce_total;
        val_before = valid_total;
        armed      = (hold_at_valid == 0);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = AW'(base);
        length    = (AW + 1)'(len);
        @(negedge clk);
        t0       = cyc;
        busy_n   = busy ? 1 : 0;
        hold_cnt = hold;
        @(posedge clk);
        #1;
        start = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int k = 0; k < 5000 && !got; k++) begin
            @(negedge clk);
            if (!armed && out_valid) begin
                hold_cnt = hold_at_valid;
                armed    = 1'b1;
            end
            if (busy) busy_n++;
            if (done) begin
                got = 1'b1;
                lat = cyc - t0;
            end
        end
        check("done_seen", got, 1);
        if (chk_lat) check("done_latency", lat, (len == 0) ? 1 : RL + len + 2);
        check("busy_cycles", busy_n, lat);
        check("beats_left", exp_q.size(), 0);
        check("reads_left", exp_adr.size(), 0);
        check("outstanding_le_depth", maxout <= FD, 1);
        if (len == 0) begin
            check("len0_no_ce0", ce_total, ce_before);
            check("len0_no_valid", valid_total, val_before);
        end
        rmode = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ce0"}, ce0, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_address0"}, address0, 0);
        check({tag, "_out_data"}, out_data, 0);
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        check("we0_const", we0, 0);
        check("d0_const", d0, 0);
        #10;
        reset_n = 1'b1;

        xfer(0, 8, 0, 0, 0, 1);
        xfer(2045, 6, 0, 0, 0, 1);
        xfer(500, 0, 0, 0, 0, 1);
        xfer(64, 16, 1, 10, 0, 0);

        // Reset in the middle of a 10-beat transfer.
        ce_total = 0;
        hs_total = 0;
        push_expected(100, 10);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = AW'(100);
        length    = (AW + 1)'(10);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 200 && hs_total < 3; k++) @(negedge clk);
        check("reset_test_three_beats", hs_total >= 3, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        exp_adr.delete();
        repeat (3) @(negedge clk);
        #2;
        reset_n  = 1'b1;
        ce_total = 0;
        hs_total = 0;
        xfer(7, 4, 0, 0, 0, 1);
        check("post_reset_beats", hs_total, 4);

        xfer(300, 4, 0, 0, 5, 0);
`ifdef KNN_SP_READER_STATS_EN
        check("stall_cycles", stall_cycles, 5);
        check("beats_out", beats_out, 4);
`endif

        for (int r = 0; r < 4; r++) begin
            xfer(int'($urandom_range(0, AR - 1)), int'($urandom_range(1, 24)), 1,
                 int'($urandom_range(0, 6)), 0, 0);
        end

        xfer(2047, AR, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
